evt_sync_rx: RTL and testbench
==============================

# evt_sync_rx

Clocked receiver at the tail of a two-phase event-latch micropipeline. It synchronises the pipeline's transition-signalled request into the clock domain and captures the bundled data into a small FIFO. It returns a transition-signalled acknowledge only once the word is stored, and presents the words to synchronous logic on a valid/ready interface. Upstream backpressure happens by withholding the acknowledge when the FIFO is full.

## Interface

- width, 8, data word width in bits
- SYNC_STAGES, 2, flops in the request synchroniser (minimum 2)
- DEPTH, 2, FIFO depth in words (power of 2, minimum 2)

- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req_in  input  1  two-phase request from the last pipeline stage; each transition is one event
- data_in  input  width  bundled data; stable from req_in transition until matching ack_out transition
- ack_out  output  1  two-phase acknowledge to the last pipeline stage, registered
- data_out  output  width  FIFO head word, registered
- valid_out  output  1  FIFO non-empty
- ready_in  input  1  consumer accepts head when valid_out && ready_in
- level  output  $clog2(DEPTH)+1  FIFO occupancy

## Operation

- Synchroniser: req_in passes through a SYNC_STAGES-flop chain; the last stage is req_s. No other logic samples req_in directly.
- Phase register req_seen, reset 0. ack_out is req_seen driven from a flop.
- Event pending: req_s != req_seen.
- Push: pending && level < DEPTH, with level taken from the registered value at the start of the cycle.
  - Write data_in at the tail.
  - Set req_seen <= req_s, which toggles ack_out.
- Pending with a full FIFO:
  - No write and no ack toggle.
  - The upstream pipeline stalls, and data_in stays held by protocol.
- Pop: valid_out && ready_in. The head advances and data_out shows the next word, or holds its last value when the FIFO becomes empty.
- Simultaneous push and pop:
  - When not full at cycle start: both occur and level is unchanged.
  - When full at cycle start: only the pop occurs. The push happens the following cycle if the event is still pending.
- Pointers: $clog2(DEPTH)-bit read/write pointers wrap modulo DEPTH. level is an explicit counter and never exceeds DEPTH or goes below 0.
- Pop while empty: ignored, no state change.
- At most one event is consumed per cycle.
  - A second upstream transition cannot arrive before ack_out toggles, so no events are lost.
  - A req_in glitch that returns to its prior level inside the synchroniser produces no event.

## Timing

- Reset values, forced immediately on rst assertion:
  - ack_out 0, valid_out 0, data_out 0, level 0.
  - Synchroniser flops 0, req_seen 0, pointers 0.
- The upstream pipeline is reset by the same rst, with its req at 0.
- Reset mid-operation: pending and stored words are discarded, and ack_out returns to 0. Operation resumes on the first clk edge after rst deasserts.
- Latency, req_in toggling between edges E0 and E1, with an empty FIFO:
  - req_s updates after edge E(SYNC_STAGES).
  - Push at edge E(SYNC_STAGES+1).
  - After that edge, ack_out has toggled, valid_out=1, data_out=word and level=1.
  - With default parameters, this is 3 edges.
- Pop-to-space: a pop at edge N frees a slot usable by a push at edge N+1.
- Throughput: at most one event per SYNC_STAGES+1 cycles plus the upstream round-trip delay.
- Data setup: the upstream matched-delay bundling guarantees data_in is settled before req_in transitions. SYNC_STAGES ≥ 2 adds at least one cycle of margin before the sample.

## Test plan

- Reset:
  - Stimulus: rst=1 mid-stream with level=2.
  - Response: ack_out, valid_out, level and data_out go to 0 immediately. After release, a req_in toggle with data_in=0xA5 gives data_out=0xA5 and valid_out=1 exactly 3 edges later.
- Single event latency:
  - Stimulus: req_in 0→1 with data_in=0x3C, ready_in=0.
  - Response: ack_out 0→1 and level=1 at edge 3. No further ack change.
- Backpressure:
  - Stimulus: ready_in=0, four events 0x01..0x04 from a model upstream that waits for each ack.
  - Response: only 0x01 and 0x02 are acked and level=2; ack_out holds with the third event pending. Raising ready_in for 1 cycle pops 0x01, and the next edge pushes 0x03 with an ack toggle.
- Full with simultaneous pop:
  - Stimulus: level=2, event pending, ready_in=1.
  - Response: pop at edge N with level=1, push at N+1 with level=2. Order is preserved.
- Streaming with wrap:
  - Stimulus: 20 random words, ready_in toggling randomly, random upstream delays of 0–5 cycles.
  - Response: the output sequence equals the input sequence, pointers wrap, level stays within 0..2, and ack transitions equal 20.
- Glitch and idle:
  - Stimulus: a req_in pulse shorter than half a clk period that returns to its prior level between edges.
  - Response: no push, and ack_out and level are unchanged.

Source files
------------

// File: rtl/evt_sync_rx.sv
// evt_sync_rx: clocked tail of a two-phase micropipeline.
// Synchronises the transition-signalled request, stores the bundled word
// in a small FIFO, toggles the acknowledge once the word is stored, and
// presents stored words on a valid/ready interface.
module evt_sync_rx #(
    parameter int width       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_in,
    input  logic [width-1:0]         data_in,
    output logic                     ack_out,
    output logic [width-1:0]         data_out,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic                   req_seen;
    logic [PW-1:0]          wr_ptr, rd_ptr, rd_ptr_n;
    logic [LW-1:0]          level_n;
    logic [width-1:0]       mem [DEPTH];
    logic [width-1:0]       head_n;
    logic                   pending, full, push, pop;

    assign req_s     = sync_q[SYNC_STAGES-1];
    assign ack_out   = req_seen;
    assign valid_out = (level != '0);

    // Request synchroniser chain; req_in is sampled nowhere else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
    end

    // Push/pop decisions from start-of-cycle state, next head word.
    always_comb begin
        pending  = (req_s != req_seen);
        full     = (level == LW'(DEPTH));
        push     = pending && !full;
        pop      = valid_out && ready_in;
        rd_ptr_n = pop ? rd_ptr + PW'(1) : rd_ptr;
        level_n  = level;
        case ({push, pop})
            2'b10:   level_n = level + LW'(1);
            2'b01:   level_n = level - LW'(1);
            default: level_n = level;
        endcase
        // A word written this cycle into the slot that becomes head bypasses mem.
        head_n = (push && (wr_ptr == rd_ptr_n)) ? data_in : mem[rd_ptr_n];
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    // Phase register, pointers, occupancy and registered head word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_seen <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            data_out <= '0;
        end else begin
            if (push) begin
                req_seen <= req_s;
                wr_ptr   <= wr_ptr + PW'(1);
            end
            rd_ptr <= rd_ptr_n;
            level  <= level_n;
            // Hold the last word when the FIFO drains.
            if (level_n != '0) data_out <= head_n;
        end
    end
endmodule

// File: tb/tb_evt_sync_rx.sv
// Directed bench for evt_sync_rx: cycle table plus glitch, reset and
// randomised streaming sequences against a queue scoreboard.
module tb_evt_sync_rx;
    logic       clk, rst, req_in, ack_out, valid_out, ready_in;
    logic [7:0] data_in, data_out;
    logic [1:0] level;

    int tests = 0;
    int fails = 0;

    evt_sync_rx #(.width(8), .SYNC_STAGES(2), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .data_in(data_in),
        .ack_out(ack_out), .data_out(data_out), .valid_out(valid_out),
        .ready_in(ready_in), .level(level)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       req;
        logic [7:0] d;
        logic       rdy;
        logic       ack;
        logic       vld;
        logic [7:0] dout;
        logic [1:0] lvl;
    } vec_t;

    vec_t tbl[$];
    logic [7:0] expq[$];

    task automatic add(input logic rq, input logic [7:0] d, input logic rdy,
                       input logic ack, input logic vld, input logic [7:0] dout,
                       input logic [1:0] lvl);
        vec_t v;
        v.req = rq; v.d = d; v.rdy = rdy; v.ack = ack;
        v.vld = vld; v.dout = dout; v.lvl = lvl;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; req_in = 0; data_in = 0; ready_in = 0;
        #2;
        chk("rst.ack", ack_out, 0);
        chk("rst.valid", valid_out, 0);
        chk("rst.level", level, 0);
        chk("rst.data", data_out, 0);
        tick();
        rst = 0;

        //   req  d      rdy  ack vld dout   lvl
        // single event 0x3C, latency 3 edges, then idle
        add(1, 8'h3C, 0,   0,  0,  8'h00, 0);
        add(1, 8'h3C, 0,   0,  0,  8'h00, 0);
        add(1, 8'h3C, 0,   1,  1,  8'h3C, 1);
        add(1, 8'h3C, 0,   1,  1,  8'h3C, 1);
        // second event fills the FIFO
        add(0, 8'h5A, 0,   1,  1,  8'h3C, 1);
        add(0, 8'h5A, 0,   1,  1,  8'h3C, 1);
        add(0, 8'h5A, 0,   0,  1,  8'h3C, 2);
        // third event held off while full
        add(1, 8'h77, 0,   0,  1,  8'h3C, 2);
        add(1, 8'h77, 0,   0,  1,  8'h3C, 2);
        add(1, 8'h77, 0,   0,  1,  8'h3C, 2);
        add(1, 8'h77, 0,   0,  1,  8'h3C, 2);
        // pop while full and pending: pop only, push on the next edge
        add(1, 8'h77, 1,   0,  1,  8'h5A, 1);
        add(1, 8'h77, 0,   1,  1,  8'h5A, 2);
        // drain, then pop while empty is ignored
        add(1, 8'h77, 1,   1,  1,  8'h77, 1);
        add(1, 8'h77, 1,   1,  0,  8'h77, 0);
        add(1, 8'h77, 1,   1,  0,  8'h77, 0);
        // simultaneous push and pop at level 1
        add(0, 8'h11, 0,   1,  0,  8'h77, 0);
        add(0, 8'h11, 0,   1,  0,  8'h77, 0);
        add(0, 8'h11, 0,   0,  1,  8'h11, 1);
        add(1, 8'h22, 0,   0,  1,  8'h11, 1);
        add(1, 8'h22, 0,   0,  1,  8'h11, 1);
        add(1, 8'h22, 1,   1,  1,  8'h22, 1);
        add(1, 8'h22, 0,   1,  1,  8'h22, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            req_in = tbl[i].req; data_in = tbl[i].d; ready_in = tbl[i].rdy;
            tick();
            chk($sformatf("row%0d.ack", i), ack_out, tbl[i].ack);
            chk($sformatf("row%0d.valid", i), valid_out, tbl[i].vld);
            chk($sformatf("row%0d.data", i), data_out, tbl[i].dout);
            chk($sformatf("row%0d.level", i), level, tbl[i].lvl);
        end

        // Glitch: req_in dips and returns well inside one clock period.
        req_in = 0;
        #3;
        req_in = 1;
        repeat (5) tick();
        chk("glitch.ack", ack_out, 1);
        chk("glitch.level", level, 1);
        chk("glitch.data", data_out, 8'h22);

        // Fill to level 2, then reset mid-cycle.
        req_in = 0; data_in = 8'h33;
        repeat (3) tick();
        chk("prerst.level", level, 2);
        chk("prerst.ack", ack_out, 0);
        #3;
        rst = 1;
        #1;
        chk("midrst.ack", ack_out, 0);
        chk("midrst.valid", valid_out, 0);
        chk("midrst.level", level, 0);
        chk("midrst.data", data_out, 0);
        tick();
        tick();
        rst = 0; req_in = 1; data_in = 8'hA5;
        tick();
        tick();
        chk("postrst.e2.valid", valid_out, 0);
        tick();
        chk("postrst.e3.valid", valid_out, 1);
        chk("postrst.e3.data", data_out, 8'hA5);
        chk("postrst.e3.ack", ack_out, 1);
        chk("postrst.e3.level", level, 1);

        // Streaming: 20 random words, random delays and random ready.
        expq.push_back(8'hA5);
        fork
            begin : producer
                for (int i = 0; i < 20; i++) begin
                    int dly;
                    int wt;
                    dly = $urandom_range(0, 5);
                    repeat (dly) tick();
                    data_in = 8'($urandom_range(0, 255));
                    expq.push_back(data_in);
                    req_in = ~req_in;
                    wt = 0;
                    while (ack_out != req_in && wt < 200) begin
                        tick();
                        wt++;
                    end
                    if (ack_out != req_in) chk($sformatf("stream.ack_wait%0d", i), ack_out, req_in);
                end
            end
            begin : consumer
                int got;
                int cyc;
                int acks;
                logic prev;
                got = 0; cyc = 0; acks = 0; prev = ack_out;
                while (got < 21 && cyc < 5000) begin
                    if (ack_out != prev) acks++;
                    prev = ack_out;
                    chk("stream.level_le2", level <= 2'd2, 1);
                    ready_in = 1'($urandom_range(0, 1));
                    if (valid_out && ready_in) begin
                        if (expq.size() == 0) begin
                            chk("stream.unexpected_word", data_out, 0);
                            chk("stream.unexpected_word_flag", 1, 0);
                        end else begin
                            chk($sformatf("stream.word%0d", got), data_out, expq.pop_front());
                        end
                        got++;
                    end
                    tick();
                    cyc++;
                end
                ready_in = 0;
                chk("stream.words", got, 21);
                chk("stream.ack_transitions", acks, 20);
            end
        join
        chk("stream.final_level", level, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
